msg_tx: RTL and testbench
=========================

Name: msg_tx

Overview:
- Message transmitter for the messaging unit: serializes fixed 12-byte ASCII frames (IFM unit-activation and PBM block-ID messages) onto a single UART line, 8N1.
- Frame layout and bit timing match the 12-byte receive path, so a tx → rx loopback decodes unit and block IDs.
- Sits between the control logic (single-cycle send requests) and the serial output pin.

Parameters:
- CLKS_PER_BIT, 4340, clk_50M cycles per UART bit; 11520 baud at 50 MHz, matching the receive-side 4339+1 count.
- FRAME_LEN, 12, bytes per frame; fixed and not intended to be overridden.

Ports:
- clk_50M  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- send_ifm  in  1  single-cycle request: send IFM frame for unit_sel
- send_pbm  in  1  single-cycle request: send PBM frame for block_id
- unit_sel  in  2  0=E (0x45), 1=C (0x43), 2=R (0x52), 3=invalid
- block_id  in  3  valid range 1..4, sent as ASCII '1'..'4' (0x31..0x34)
- tx  out  1  serial line, idle high
- busy  out  1  high from request acceptance until frame end
- done  out  1  one-cycle pulse after the last stop bit of a frame
- err  out  1  one-cycle pulse when a request is rejected for bad arguments

Behaviour:
- Reset (async, rst_n=0): tx=1, busy=0, done=0, err=0, FSM=IDLE, byte index=0, bit counter=0. Reset mid-frame aborts immediately; tx returns high within the reset assertion. No partial frame resumes after reset.
- IFM frame bytes:
  - 0-2 = "IFM" (0x49 0x46 0x4D)
  - 3 = unit char
  - 4-10 = 0x2D ('-')
  - 11 = 0x23 ('#')
- PBM frame bytes:
  - 0-2 = "PBM" (0x50 0x42 0x4D)
  - 3-4 = "SU" (0x53 0x55)
  - 5 = 0x30+block_id
  - 6-10 = 0x2D
  - 11 = 0x23
- Request acceptance:
  - Requests are sampled only in IDLE.
  - unit_sel and block_id are captured in the same cycle as the request and held for the whole frame.
  - send_ifm and send_pbm high in the same cycle: IFM wins and the PBM request is dropped.
  - Requests while busy=1 are ignored, with no queuing and no err.
- Argument checks:
  - send_ifm with unit_sel=3 → err pulse the next cycle, no transmission, busy stays 0.
  - send_pbm with block_id outside 1..4 → same behaviour as above.
- FSM states: IDLE → START → DATA → STOP → (next byte: START | last byte: DONE) → IDLE.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
  - No idle gap between bytes: the next start bit follows the stop bit directly.
  - DONE: one cycle with done=1 and busy=0, then IDLE. A request is accepted in the cycle after done.
- Latency: request at cycle N → busy=1 and tx=0 (start bit) from cycle N+1.
- Frame length: 12×10×CLKS_PER_BIT cycles from the first start-bit cycle to the end of the last stop bit. done is high on the following cycle.
- Counter width: bit counter is $clog2(CLKS_PER_BIT) bits and wraps to 0 at CLKS_PER_BIT-1. Bit index is 3 bits, byte index is 4 bits.
- tx is driven from a register (glitch-free).

Decomposition:
- Package msg_pkg holds:
  - ASCII constants: IFM/PBM headers, 'S', 'U', unit chars E/C/R, PAD=0x2D, TERM=0x23, digit base 0x30.
  - FRAME_LEN=12.
  - Unit-select encoding and FSM state typedef.
- Sub-module uart_tx_byte: byte serializer with byte_in[7:0], start, busy and done.
- msg_tx keeps frame construction, byte sequencing, argument checks and the request handshake.

Test Plan (bench sets CLKS_PER_BIT=4, so one frame = 480 cycles):
- send_ifm, unit_sel=1 → bench UART decoder captures "IFMC-------#"; busy high for 480 cycles; single done pulse at cycle 481 after the request.
- send_pbm, block_id=3 → captures "PBMSU3-----#"; byte 5 = 0x33; start bit of byte 0 begins one cycle after the request.
- send_ifm and send_pbm in the same cycle with unit_sel=2 → only "IFMR-------#" sent. Then send_pbm pulsed at frame cycle 100 → ignored, no second frame, err stays 0.
- send_pbm with block_id=0, then with block_id=5, then send_ifm with unit_sel=3 → err pulse each time one cycle later; tx stays 1; busy stays 0.
- rst_n low at frame cycle 200 (mid-byte) → tx=1, busy=0 asynchronously. After release, send_ifm with unit_sel=0 yields a clean "IFME-------#".
- Loopback: tx feeds the receive block, with CLKS_PER_BIT matched on both sides. Send IFM(E) then PBM(block 2) → receiver reports EU_active=1 and esu_block_id=2.

Source files
------------

// File: rtl/msg_pkg.sv
// Shared constants, encodings and frame-byte lookup for the 12-byte IFM/PBM message transmitter.
package msg_pkg;

    localparam int         FRAME_LEN  = 12;
    localparam logic [3:0] LAST_IDX   = 4'(FRAME_LEN - 1);

    localparam logic [7:0] CH_I       = 8'h49;
    localparam logic [7:0] CH_F       = 8'h46;
    localparam logic [7:0] CH_M       = 8'h4D;
    localparam logic [7:0] CH_P       = 8'h50;
    localparam logic [7:0] CH_B       = 8'h42;
    localparam logic [7:0] CH_S       = 8'h53;
    localparam logic [7:0] CH_U       = 8'h55;
    localparam logic [7:0] CH_E       = 8'h45;
    localparam logic [7:0] CH_C       = 8'h43;
    localparam logic [7:0] CH_R       = 8'h52;
    localparam logic [7:0] PAD        = 8'h2D;
    localparam logic [7:0] TERM       = 8'h23;
    localparam logic [7:0] DIGIT_BASE = 8'h30;

    typedef enum logic [1:0] {UNIT_E = 2'd0, UNIT_C = 2'd1, UNIT_R = 2'd2, UNIT_INV = 2'd3} unit_sel_t;

    // Serial-line view of the transmitter; ST_DONE only exists at frame level.
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_DONE} tx_state_t;

    typedef enum logic [1:0] {FR_IDLE, FR_BUSY, FR_DONE} frame_state_t;

    function automatic logic [7:0] unit_char(input logic [1:0] u);
        logic [7:0] c;
        case (u)
            UNIT_E:  c = CH_E;
            UNIT_C:  c = CH_C;
            UNIT_R:  c = CH_R;
            default: c = PAD;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] frame_byte(input logic is_ifm, input logic [1:0] unit,
                                              input logic [2:0] blk, input logic [3:0] idx);
        logic [7:0] b;
        b = PAD;
        if (idx == LAST_IDX) begin
            b = TERM;
        end else if (is_ifm) begin
            case (idx)
                4'd0:    b = CH_I;
                4'd1:    b = CH_F;
                4'd2:    b = CH_M;
                4'd3:    b = unit_char(unit);
                default: b = PAD;
            endcase
        end else begin
            case (idx)
                4'd0:    b = CH_P;
                4'd1:    b = CH_B;
                4'd2:    b = CH_M;
                4'd3:    b = CH_S;
                4'd4:    b = CH_U;
                4'd5:    b = DIGIT_BASE + {5'd0, blk};
                default: b = PAD;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/msg_if.sv
// Request/status bundle between the control logic (master) and the message transmitter (slave).
interface msg_if;
    import msg_pkg::*;

    // Requests are single-cycle pulses; they are honoured only while busy=0 and
    // done=0, otherwise silently dropped. unit_sel/block_id are sampled with the pulse.
    logic       send_ifm;
    logic       send_pbm;
    logic [1:0] unit_sel;
    logic [2:0] block_id;
    logic       tx;
    logic       busy;
    logic       done;
    logic       err;
    tx_state_t  state;

    modport master (output send_ifm, send_pbm, unit_sel, block_id,
                    input  tx, busy, done, err, state);
    modport slave  (input  send_ifm, send_pbm, unit_sel, block_id,
                    output tx, busy, done, err, state);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; a start asserted in the last stop-bit cycle chains the next byte with no gap.
module uart_tx_byte
    import msg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4340
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output tx_state_t  state
);

    localparam int             CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (cnt == CNT_MAX);
    // Marks the final cycle of the stop bit, the only cycle a chained start is taken.
    assign done    = (state == ST_STOP) && bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg <= byte_in;
                        tx    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        tx      <= shreg[0];
                        bit_idx <= 3'd0;
                        state   <= ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (start) begin
                            shreg <= byte_in;
                            tx    <= 1'b0;
                            state <= ST_START;
                        end else begin
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/msg_tx.sv
// Message transmitter: validates requests, builds IFM/PBM frames and sequences them through the serializer.
module msg_tx
    import msg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4340
) (
    input  logic   clk_50M,
    input  logic   rst_n,
    msg_if.slave   bus
);

    frame_state_t fstate;
    logic [3:0]   byte_idx;
    logic         is_ifm_q;
    logic [1:0]   unit_q;
    logic [2:0]   blk_q;
    logic         busy_q, done_q, err_q;

    logic         unit_ok, blk_ok, ifm_ok, pbm_ok, bad_req, accept;
    logic         ser_start, ser_done, ser_busy, ser_tx;
    logic [7:0]   ser_byte;
    tx_state_t    ser_state;

    always_comb begin
        unit_ok   = (bus.unit_sel != UNIT_INV);
        blk_ok    = (bus.block_id >= 3'd1) && (bus.block_id <= 3'd4);
        ifm_ok    = bus.send_ifm && unit_ok;
        pbm_ok    = !bus.send_ifm && bus.send_pbm && blk_ok;
        bad_req   = (bus.send_ifm && !unit_ok) || (!bus.send_ifm && bus.send_pbm && !blk_ok);
        accept    = (fstate == FR_IDLE) && (ifm_ok || pbm_ok);
        ser_start = 1'b0;
        ser_byte  = frame_byte(is_ifm_q, unit_q, blk_q, byte_idx + 4'd1);
        // Byte 0 comes straight from the live request so the start bit appears one cycle later.
        if (fstate == FR_IDLE) begin
            ser_start = accept;
            ser_byte  = frame_byte(bus.send_ifm, bus.unit_sel, bus.block_id, 4'd0);
        end else if (fstate == FR_BUSY) begin
            ser_start = ser_done && (byte_idx != LAST_IDX);
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            fstate   <= FR_IDLE;
            byte_idx <= 4'd0;
            is_ifm_q <= 1'b0;
            unit_q   <= 2'd0;
            blk_q    <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (fstate)
                FR_IDLE: begin
                    if (accept) begin
                        busy_q   <= 1'b1;
                        byte_idx <= 4'd0;
                        is_ifm_q <= bus.send_ifm;
                        unit_q   <= bus.unit_sel;
                        blk_q    <= bus.block_id;
                        fstate   <= FR_BUSY;
                    end else if (bad_req) begin
                        err_q <= 1'b1;
                    end
                end
                FR_BUSY: begin
                    if (ser_done) begin
                        if (byte_idx == LAST_IDX) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            fstate <= FR_DONE;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                        end
                    end
                end
                default: begin
                    byte_idx <= 4'd0;
                    fstate   <= FR_IDLE;
                end
            endcase
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
        .clk     (clk_50M),
        .rst_n   (rst_n),
        .start   (ser_start),
        .byte_in (ser_byte),
        .tx      (ser_tx),
        .busy    (ser_busy),
        .done    (ser_done),
        .state   (ser_state)
    );

    assign bus.tx    = ser_tx;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.state = (fstate == FR_DONE) ? ST_DONE : (ser_busy ? ser_state : ST_IDLE);

endmodule

// File: tb/tb_msg_tx.sv
// Directed bench for msg_tx: decodes the serial line itself and checks frames, timing and rejects.
module tb_msg_tx;
    import msg_pkg::*;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = FRAME_LEN * 10 * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    msg_if bus ();

    msg_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_50M (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [7:0] cap [FRAME_LEN];
    int         busy_bad, done_cnt, done_at, err_cnt, frame_bad;
    logic       first_tx;

    task automatic do_req(input logic ifm, input logic pbm, input logic [1:0] u, input logic [2:0] b);
        @(posedge clk); #1;
        bus.send_ifm = ifm;
        bus.send_pbm = pbm;
        bus.unit_sel = u;
        bus.block_id = b;
        @(posedge clk); #1;
        bus.send_ifm = 1'b0;
        bus.send_pbm = 1'b0;
    endtask

    // Called right after the accepting edge; c=0 is the first start-bit cycle.
    task automatic capture(input int mid_at);
        int bn, k;
        busy_bad = 0; done_cnt = 0; done_at = -1; err_cnt = 0; frame_bad = 0;
        for (int i = 0; i < FRAME_LEN; i++) cap[i] = 8'h00;
        for (int c = 0; c < FRAME_CYC + 10; c++) begin
            @(negedge clk);
            if (c == 0) first_tx = bus.tx;
            if (bus.busy !== (c < FRAME_CYC)) busy_bad++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (bus.err !== 1'b0) err_cnt++;
            if (c < FRAME_CYC && (c % CPB) == CPB / 2) begin
                bn = c / CPB;
                k  = bn % 10;
                if (k == 0) begin
                    if (bus.tx !== 1'b0) frame_bad++;
                end else if (k == 9) begin
                    if (bus.tx !== 1'b1) frame_bad++;
                end else begin
                    cap[bn / 10][k - 1] = bus.tx;
                end
            end
            if (c >= FRAME_CYC && bus.tx !== 1'b1) frame_bad++;
            if (c == mid_at) begin
                bus.send_pbm = 1'b1;
                bus.block_id = 3'd1;
                bus.unit_sel = 2'd0;
            end
            if (c == mid_at + 1) bus.send_pbm = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++; if (bus.tx !== 1'b1) $display("FAIL reset_tx got %b want 1", bus.tx); else pass_cnt++;
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
        chk_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else pass_cnt++;
        chk_cnt++; if (bus.err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.err); else pass_cnt++;
        chk_cnt++; if (bus.state !== ST_IDLE) $display("FAIL reset_state got %0d want %0d", bus.state, ST_IDLE); else pass_cnt++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ifm();
        string exp = "IFMC-------#";
        do_req(1'b1, 1'b0, 2'd1, 3'd0);
        capture(60);
        for (int i = 0; i < FRAME_LEN; i++) begin
            chk_cnt++; if (cap[i] !== exp[i]) $display("FAIL ifm_byte%0d got %h want %h", i, cap[i], exp[i]); else pass_cnt++;
        end
        chk_cnt++; if (busy_bad !== 0) $display("FAIL ifm_busy_window got %0d bad cycles want 0", busy_bad); else pass_cnt++;
        chk_cnt++; if (done_cnt !== 1) $display("FAIL ifm_done_count got %0d want 1", done_cnt); else pass_cnt++;
        chk_cnt++; if (done_at !== FRAME_CYC) $display("FAIL ifm_done_cycle got %0d want %0d", done_at, FRAME_CYC); else pass_cnt++;
        chk_cnt++; if (frame_bad !== 0) $display("FAIL ifm_framing got %0d bad bits want 0", frame_bad); else pass_cnt++;
        chk_cnt++; if (bus.state !== ST_IDLE) $display("FAIL ifm_end_state got %0d want %0d", bus.state, ST_IDLE); else pass_cnt++;
    endtask

    task automatic test_pbm();
        string exp = "PBMSU3-----#";
        do_req(1'b0, 1'b1, 2'd0, 3'd3);
        capture(100);
        for (int i = 0; i < FRAME_LEN; i++) begin
            chk_cnt++; if (cap[i] !== exp[i]) $display("FAIL pbm_byte%0d got %h want %h", i, cap[i], exp[i]); else pass_cnt++;
        end
        chk_cnt++; if (cap[5] !== 8'h33) $display("FAIL pbm_digit got %h want 33", cap[5]); else pass_cnt++;
        chk_cnt++; if (first_tx !== 1'b0) $display("FAIL pbm_start_latency got %b want 0", first_tx); else pass_cnt++;
        chk_cnt++; if (done_at !== FRAME_CYC) $display("FAIL pbm_done_cycle got %0d want %0d", done_at, FRAME_CYC); else pass_cnt++;
        chk_cnt++; if (frame_bad !== 0) $display("FAIL pbm_framing got %0d bad bits want 0", frame_bad); else pass_cnt++;
    endtask

    task automatic test_both_and_busy_ignore();
        string exp = "IFMR-------#";
        do_req(1'b1, 1'b1, 2'd2, 3'd3);
        capture(100);
        for (int i = 0; i < FRAME_LEN; i++) begin
            chk_cnt++; if (cap[i] !== exp[i]) $display("FAIL both_byte%0d got %h want %h", i, cap[i], exp[i]); else pass_cnt++;
        end
        chk_cnt++; if (err_cnt !== 0) $display("FAIL both_err got %0d pulses want 0", err_cnt); else pass_cnt++;
        chk_cnt++; if (done_cnt !== 1) $display("FAIL both_done_count got %0d want 1", done_cnt); else pass_cnt++;
        chk_cnt++; if (frame_bad !== 0) $display("FAIL both_no_second_frame got %0d bad bits want 0", frame_bad); else pass_cnt++;
        chk_cnt++; if (busy_bad !== 0) $display("FAIL both_busy_window got %0d bad cycles want 0", busy_bad); else pass_cnt++;
    endtask

    task automatic test_bad_args();
        logic       v_ifm [3] = '{1'b0, 1'b0, 1'b1};
        logic       v_pbm [3] = '{1'b1, 1'b1, 1'b0};
        logic [1:0] v_u   [3] = '{2'd0, 2'd0, 2'd3};
        logic [2:0] v_b   [3] = '{3'd0, 3'd5, 3'd1};
        for (int i = 0; i < 3; i++) begin
            do_req(v_ifm[i], v_pbm[i], v_u[i], v_b[i]);
            @(negedge clk);
            chk_cnt++; if (bus.err !== 1'b1) $display("FAIL bad%0d_err got %b want 1", i, bus.err); else pass_cnt++;
            chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL bad%0d_busy got %b want 0", i, bus.busy); else pass_cnt++;
            chk_cnt++; if (bus.tx !== 1'b1) $display("FAIL bad%0d_tx got %b want 1", i, bus.tx); else pass_cnt++;
            @(negedge clk);
            chk_cnt++; if (bus.err !== 1'b0) $display("FAIL bad%0d_err_pulse got %b want 0", i, bus.err); else pass_cnt++;
            chk_cnt++; if (bus.tx !== 1'b1) $display("FAIL bad%0d_tx_late got %b want 1", i, bus.tx); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_frame();
        string exp = "IFME-------#";
        do_req(1'b1, 1'b0, 2'd0, 3'd0);
        repeat (200) @(negedge clk);
        chk_cnt++; if (bus.busy !== 1'b1) $display("FAIL midrst_pre_busy got %b want 1", bus.busy); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (bus.tx !== 1'b1) $display("FAIL midrst_tx got %b want 1", bus.tx); else pass_cnt++;
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", bus.busy); else pass_cnt++;
        chk_cnt++; if (bus.state !== ST_IDLE) $display("FAIL midrst_state got %0d want %0d", bus.state, ST_IDLE); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_cnt++; if (bus.tx !== 1'b1) $display("FAIL midrst_no_resume got %b want 1", bus.tx); else pass_cnt++;
        do_req(1'b1, 1'b0, 2'd0, 3'd0);
        capture(-1);
        for (int i = 0; i < FRAME_LEN; i++) begin
            chk_cnt++; if (cap[i] !== exp[i]) $display("FAIL midrst_byte%0d got %h want %h", i, cap[i], exp[i]); else pass_cnt++;
        end
        chk_cnt++; if (frame_bad !== 0) $display("FAIL midrst_framing got %0d bad bits want 0", frame_bad); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        string exp = "PBMSU2-----#";
        int n = 0;
        do_req(1'b1, 1'b0, 2'd0, 3'd0);
        do begin
            @(negedge clk);
            n++;
        end while (bus.done !== 1'b1 && n < 600);
        chk_cnt++; if (n !== FRAME_CYC + 1) $display("FAIL b2b_done_wait got %0d want %0d", n, FRAME_CYC + 1); else pass_cnt++;
        do_req(1'b0, 1'b1, 2'd0, 3'd2);
        capture(-1);
        for (int i = 0; i < FRAME_LEN; i++) begin
            chk_cnt++; if (cap[i] !== exp[i]) $display("FAIL b2b_byte%0d got %h want %h", i, cap[i], exp[i]); else pass_cnt++;
        end
        chk_cnt++; if (first_tx !== 1'b0) $display("FAIL b2b_start_latency got %b want 0", first_tx); else pass_cnt++;
        chk_cnt++; if (done_at !== FRAME_CYC) $display("FAIL b2b_done_cycle got %0d want %0d", done_at, FRAME_CYC); else pass_cnt++;
    endtask

    initial begin
        bus.send_ifm = 1'b0;
        bus.send_pbm = 1'b0;
        bus.unit_sel = 2'd0;
        bus.block_id = 3'd0;
        test_reset();
        test_ifm();
        test_pbm();
        test_both_and_busy_ignore();
        test_bad_args();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
